// File: rtl/nes_sram_pkg.sv
// Shared types and constants for the CHR SRAM arbiter: FSM states, address
// widths and requester port indices.
package nes_sram_pkg;

  localparam int SRAM_AW  = 20;
  localparam int BYTE_AW  = 21;
  localparam int PORT_PPU = 0;
  localparam int PORT_CPU = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSETUP,
    WPULSE,
    WHOLD,
    DONE
  } arb_state_t;

  // A byte write drives both DQ lanes; the lane strobes pick the one stored.
  function automatic logic [15:0] dup_byte(input logic [7:0] b);
    return {b, b};
  endfunction

endpackage

// File: rtl/sram_arb_prio.sv
// Two-port fixed-priority arbiter (port 0 first) with a starvation counter
// that hands port 1 the grant after MAX_WAIT port-0 wins in a row.
module sram_arb_prio #(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_idle,
  output logic o_gnt0,
  output logic o_gnt1
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0] starve_cnt;
  logic       pick1;

  // NOTE: each output of a combinational block is assigned on every path
  // (defaults first where branches exist) so no latch is inferred.
  always_comb begin
    pick1  = i_req1 && (!i_req0 || (starve_cnt == WAIT_MAX));
    o_gnt1 = i_idle && pick1;
    o_gnt0 = i_idle && i_req0 && !pick1;
  end

  // Counts port-0 wins that were taken while port 1 was waiting.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      starve_cnt <= '0;
    end else if (o_gnt1) begin
      starve_cnt <= '0;
    end else if (o_gnt0 && i_req1 && (starve_cnt != WAIT_MAX)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/chr_sram_arbiter.sv
// Shares the 16-bit asynchronous CHR SRAM between the PPU (port 0) and the
// CPU/loader (port 1), one byte access at a time with registered strobes.
module chr_sram_arbiter
  import nes_sram_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic               i_we0,
  input  logic               i_we1,
  input  logic [BYTE_AW-1:0] i_addr0,
  input  logic [BYTE_AW-1:0] i_addr1,
  input  logic [7:0]         i_wdata0,
  input  logic [7:0]         i_wdata1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  output logic               o_done0,
  output logic               o_done1,
  output logic [7:0]         o_rdata,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n,
  output logic [15:0]        o_sram_dq,
  output logic               o_sram_dq_oe,
  input  logic [15:0]        i_sram_dq
);

  localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

  arb_state_t         state, next_state;
  logic [3:0]         cnt, cnt_nxt;
  logic               owner;
  logic               lane, lane_d;
  logic               idle, grant, active;
  logic               sel_we;
  logic [BYTE_AW-1:0] sel_addr;
  logic [7:0]         sel_wdata;

  // Arbitration is frozen while reset is asserted.
  assign idle = (state == IDLE) && i_rstn;

  sram_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_req0 (i_req0),
    .i_req1 (i_req1),
    .i_idle (idle),
    .o_gnt0 (o_gnt0),
    .o_gnt1 (o_gnt1)
  );

  always_comb begin
    grant     = o_gnt0 | o_gnt1;
    sel_we    = o_gnt1 ? i_we1    : i_we0;
    sel_addr  = o_gnt1 ? i_addr1  : i_addr0;
    sel_wdata = o_gnt1 ? i_wdata1 : i_wdata0;

    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = sel_we ? WSETUP : RD;
      RD:      if (cnt == RD_LAST) next_state = DONE;
      WSETUP:  next_state = WPULSE;
      WPULSE:  if (cnt == WR_LAST) next_state = WHOLD;
      WHOLD:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // The timing counter restarts on every state change.
    cnt_nxt = (next_state != state) ? 4'd0 : cnt + 4'd1;
    active  = next_state inside {RD, WSETUP, WPULSE, WHOLD};
    lane_d  = grant ? sel_addr[0] : lane;
  end

  // Strobes are registered from the next state so the SRAM pins never glitch
  // and DQ drive and OE_N low can never overlap.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      owner        <= 1'b0;
      lane         <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
      o_rdata      <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state        <= next_state;
      cnt          <= cnt_nxt;
      lane         <= lane_d;
      o_sram_ce_n  <= !active;
      o_sram_oe_n  <= !(next_state == RD);
      o_sram_we_n  <= !(next_state == WPULSE);
      o_sram_lb_n  <= !(active && !lane_d);
      o_sram_ub_n  <= !(active && lane_d);
      o_sram_dq_oe <= next_state inside {WSETUP, WPULSE, WHOLD};
      if (grant) begin
        owner       <= o_gnt1;
        o_sram_addr <= sel_addr[BYTE_AW-1:1];
        o_sram_dq   <= dup_byte(sel_wdata);
      end
      if ((state == RD) && (next_state == DONE)) begin
        o_rdata <= lane ? i_sram_dq[15:8] : i_sram_dq[7:0];
      end
    end
  end

  assign o_done0 = (state == DONE) && (owner == 1'(PORT_PPU));
  assign o_done1 = (state == DONE) && (owner == 1'(PORT_CPU));

endmodule

// File: tb/tb_chr_sram_arbiter.sv
// Bench for chr_sram_arbiter: directed latency/strobe scenarios plus a
// randomized two-port run scored against a cycle-level transaction model.
module tb_chr_sram_arbiter;

  localparam int RD_A = 2, WR_A = 2, MW = 4;
  localparam int RD_B = 1, WR_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: default timing
  logic        req0_a, req1_a, we0_a, we1_a;
  logic [20:0] addr0_a, addr1_a;
  logic [7:0]  wdata0_a, wdata1_a;
  logic        gnt0_a, gnt1_a, done0_a, done1_a;
  logic [7:0]  rdata_a;
  logic [19:0] saddr_a;
  logic        ce_a, oe_a, we_a, lb_a, ub_a, dqoe_a;
  logic [15:0] dq_a, din_a;
  logic [15:0] mem_a [0:4095];

  // DUT B: RD_CYCLES = 1, WR_CYCLES = 3
  logic        req0_b, req1_b, we0_b, we1_b;
  logic [20:0] addr0_b, addr1_b;
  logic [7:0]  wdata0_b, wdata1_b;
  logic        gnt0_b, gnt1_b, done0_b, done1_b;
  logic [7:0]  rdata_b;
  logic [19:0] saddr_b;
  logic        ce_b, oe_b, we_b, lb_b, ub_b, dqoe_b;
  logic [15:0] dq_b, din_b;
  logic [15:0] mem_b [0:255];

  chr_sram_arbiter #(.RD_CYCLES(RD_A), .WR_CYCLES(WR_A), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0(req0_a), .i_req1(req1_a), .i_we0(we0_a), .i_we1(we1_a),
    .i_addr0(addr0_a), .i_addr1(addr1_a), .i_wdata0(wdata0_a), .i_wdata1(wdata1_a),
    .o_gnt0(gnt0_a), .o_gnt1(gnt1_a), .o_done0(done0_a), .o_done1(done1_a),
    .o_rdata(rdata_a), .o_sram_addr(saddr_a),
    .o_sram_ce_n(ce_a), .o_sram_oe_n(oe_a), .o_sram_we_n(we_a),
    .o_sram_lb_n(lb_a), .o_sram_ub_n(ub_a),
    .o_sram_dq(dq_a), .o_sram_dq_oe(dqoe_a), .i_sram_dq(din_a)
  );

  chr_sram_arbiter #(.RD_CYCLES(RD_B), .WR_CYCLES(WR_B), .MAX_WAIT(MW)) dut_b (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0(req0_b), .i_req1(req1_b), .i_we0(we0_b), .i_we1(we1_b),
    .i_addr0(addr0_b), .i_addr1(addr1_b), .i_wdata0(wdata0_b), .i_wdata1(wdata1_b),
    .o_gnt0(gnt0_b), .o_gnt1(gnt1_b), .o_done0(done0_b), .o_done1(done1_b),
    .o_rdata(rdata_b), .o_sram_addr(saddr_b),
    .o_sram_ce_n(ce_b), .o_sram_oe_n(oe_b), .o_sram_we_n(we_b),
    .o_sram_lb_n(lb_b), .o_sram_ub_n(ub_b),
    .o_sram_dq(dq_b), .o_sram_dq_oe(dqoe_b), .i_sram_dq(din_b)
  );

  // Asynchronous SRAM models: combinational read, lane-masked write
  assign din_a = (!ce_a && !oe_a) ? mem_a[saddr_a[11:0]] : 16'h0000;
  assign din_b = (!ce_b && !oe_b) ? mem_b[saddr_b[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!ce_a && !we_a) begin
      if (!lb_a) mem_a[saddr_a[11:0]][7:0]  <= dq_a[7:0];
      if (!ub_a) mem_a[saddr_a[11:0]][15:8] <= dq_a[15:8];
    end
    if (!ce_b && !we_b) begin
      if (!lb_b) mem_b[saddr_b[7:0]][7:0]  <= dq_b[7:0];
      if (!ub_b) mem_b[saddr_b[7:0]][15:8] <= dq_b[15:8];
    end
  end

  int got_order[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    req0_a = 0; req1_a = 0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    {req0_a, req1_a, we0_a, we1_a} = '0;
    {addr0_a, addr1_a, wdata0_a, wdata1_a} = '0;
    {req0_b, req1_b, we0_b, we1_b} = '0;
    {addr0_b, addr1_b, wdata0_b, wdata1_b} = '0;
    for (int i = 0; i < 4096; i++) mem_a[i] = 16'h0;
    for (int i = 0; i < 256; i++) mem_b[i] = 16'h0;
    step();
    step();
    @(negedge clk);
    n_tests++;
    if ({ce_a, oe_a, we_a, lb_a, ub_a} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 11111", {ce_a, oe_a, we_a, lb_a, ub_a});
    end
    n_tests++;
    if (dqoe_a !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe: got %b expected 0", dqoe_a); end
    n_tests++;
    if (saddr_a !== 20'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", saddr_a); end
    n_tests++;
    if (rdata_a !== 8'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
    n_tests++;
    if ({gnt0_a, gnt1_a, done0_a, done1_a} !== 4'b0) begin
      n_fail++; $display("FAIL reset_gnt_done: got %b expected 0000", {gnt0_a, gnt1_a, done0_a, done1_a});
    end
    step();
    rstn = 1'b1;
  endtask

  task automatic test_read_p1();
    int bad = 0;
    mem_a[1] = 16'hA55A;
    req1_a = 1; we1_a = 0; addr1_a = 21'h00003;
    @(negedge clk);
    n_tests++;
    if ({gnt0_a, gnt1_a} !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b expected 01", {gnt0_a, gnt1_a}); end
    step();
    req1_a = 0; addr1_a = 21'($urandom);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      if ({ce_a, oe_a, lb_a, ub_a, done1_a} !== 5'b00100 || saddr_a !== 20'h1) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL read_strobes: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    n_tests++;
    if (done1_a !== 1'b1 || done0_a !== 1'b0) begin
      n_fail++; $display("FAIL read_done: got %b%b expected 01", done0_a, done1_a);
    end
    n_tests++;
    if (rdata_a !== 8'hA5) begin n_fail++; $display("FAIL read_data: got %h expected a5", rdata_a); end
    n_tests++;
    if (ce_a !== 1'b1) begin n_fail++; $display("FAIL read_ce_done: got %b expected 1", ce_a); end
    step();
  endtask

  // Single access on DUT A; lat is cycles from grant to done (-1 if none).
  task automatic access_a(input int p, input bit w, input logic [20:0] a, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd);
    bit g = 0;
    lat = -1; rd = 8'hxx;
    if (p == 0) begin req0_a = 1; we0_a = w; addr0_a = a; wdata0_a = wd; end
    else        begin req1_a = 1; we1_a = w; addr1_a = a; wdata1_a = wd; end
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      g = (p == 0) ? gnt0_a : gnt1_a;
      step();
      if (g) break;
    end
    if (p == 0) req0_a = 0; else req1_a = 0;
    n_tests++;
    if (!g) begin n_fail++; $display("FAIL access_grant_timeout: port %0d got no grant expected one", p); end
    else begin
      for (int t = 1; t <= 20; t++) begin
        @(negedge clk);
        if ((p == 0) ? done0_a : done1_a) begin
          lat = t; rd = rdata_a; step(); break;
        end
        step();
      end
    end
  endtask

  task automatic test_write_p0();
    int we_lo = 0, oe_cnt = 0, done_at = -1, bad = 0, lat;
    logic [7:0] rd;
    mem_a[8] = 16'h7700;
    req0_a = 1; we0_a = 1; addr0_a = 21'h00010; wdata0_a = 8'h3C;
    @(negedge clk);
    n_tests++;
    if (gnt0_a !== 1'b1) begin n_fail++; $display("FAIL write_gnt: got %b expected 1", gnt0_a); end
    step();
    req0_a = 0; wdata0_a = 8'($urandom); addr0_a = 21'($urandom);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (!we_a) we_lo++;
      if (dqoe_a) begin
        oe_cnt++;
        if (dq_a !== 16'h3C3C || saddr_a !== 20'h8 || lb_a !== 1'b0 || ub_a !== 1'b1) bad++;
      end
      if (!oe_a) bad++;
      if (done0_a && done_at < 0) done_at = t;
      step();
    end
    n_tests++;
    if (we_lo != 2) begin n_fail++; $display("FAIL write_we_pulse: got %0d expected 2", we_lo); end
    n_tests++;
    if (oe_cnt != 4) begin n_fail++; $display("FAIL write_dq_oe_len: got %0d expected 4", oe_cnt); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL write_bus: got %0d bad cycles expected 0", bad); end
    n_tests++;
    if (done_at != 5) begin n_fail++; $display("FAIL write_done_lat: got %0d expected 5", done_at); end
    n_tests++;
    if (mem_a[8] !== 16'h773C) begin n_fail++; $display("FAIL write_lane: got %h expected 773c", mem_a[8]); end
    access_a(0, 0, 21'h00010, 8'h00, lat, rd);
    n_tests++;
    if (lat != 3 || rd !== 8'h3C) begin
      n_fail++; $display("FAIL write_readback: got lat %0d data %h expected lat 3 data 3c", lat, rd);
    end
  endtask

  // Hold both requests and record which port wins each of the next n grants.
  task automatic hold_both(input int n);
    int bad = 0;
    got_order.delete();
    req0_a = 1; we0_a = 0; addr0_a = 21'h00100;
    req1_a = 1; we1_a = 0; addr1_a = 21'h00201;
    for (int t = 0; t < 100 && got_order.size() < n; t++) begin
      @(negedge clk);
      if (gnt0_a && gnt1_a) bad++;
      if (done0_a && done1_a) bad++;
      if (gnt0_a) got_order.push_back(0);
      else if (gnt1_a) got_order.push_back(1);
      step();
    end
    req0_a = 0; req1_a = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (done0_a && done1_a) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL hold_overlap: got %0d overlaps expected 0", bad); end
    n_tests++;
    if (got_order.size() != n) begin
      n_fail++; $display("FAIL hold_count: got %0d grants expected %0d", got_order.size(), n);
    end
  endtask

  task automatic test_back_to_back();
    int exp_ord[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    apply_reset();
    hold_both(10);
    for (int i = 0; i < 10 && i < got_order.size(); i++) begin
      n_tests++;
      if (got_order[i] != exp_ord[i]) begin
        n_fail++; $display("FAIL order[%0d]: got %0d expected %0d", i, got_order[i], exp_ord[i]);
      end
    end
  endtask

  task automatic test_simul_rise();
    int exp_ord[5] = '{0, 0, 0, 0, 1};
    int lat;
    logic [7:0] rd;
    apply_reset();
    access_a(0, 0, 21'h00004, 8'h00, lat, rd);
    access_a(0, 0, 21'h00005, 8'h00, lat, rd);
    hold_both(5);
    for (int i = 0; i < 5 && i < got_order.size(); i++) begin
      n_tests++;
      if (got_order[i] != exp_ord[i]) begin
        n_fail++; $display("FAIL simul_order[%0d]: got %0d expected %0d", i, got_order[i], exp_ord[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int done_at = -1, d0 = 0;
    logic [7:0] rd = 8'h00;
    req0_a = 1; we0_a = 1; addr0_a = 21'h00040; wdata0_a = 8'h99;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = gnt0_a;
      step();
    end
    req0_a = 0;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = !we_a;
      if (!seen) step();
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_wpulse: got no we_n pulse expected one"); end
    step();
    rstn = 0;
    step();
    rstn = 1;
    req1_a = 1; we1_a = 0; addr1_a = 21'h00002;
    @(negedge clk);
    n_tests++;
    if ({ce_a, oe_a, we_a, lb_a, ub_a, dqoe_a} !== 6'b111110) begin
      n_fail++; $display("FAIL rstmid_bus: got %b expected 111110", {ce_a, oe_a, we_a, lb_a, ub_a, dqoe_a});
    end
    n_tests++;
    if (gnt1_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_regrant: got %b expected 1", gnt1_a); end
    if (done0_a) d0++;
    step();
    req1_a = 0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (done0_a) d0++;
      if (done1_a && done_at < 0) begin done_at = t; rd = rdata_a; end
      step();
    end
    n_tests++;
    if (d0 != 0) begin n_fail++; $display("FAIL rstmid_no_done0: got %0d pulses expected 0", d0); end
    n_tests++;
    if (done_at != 3 || rd !== 8'h5A) begin
      n_fail++; $display("FAIL rstmid_read: got lat %0d data %h expected lat 3 data 5a", done_at, rd);
    end
  endtask

  task automatic test_timing_b();
    int we_lo = 0, done_at = -1;
    logic [7:0] rd = 8'h00;
    req1_b = 1; we1_b = 1; addr1_b = 21'h00021; wdata1_b = 8'h5A;
    @(negedge clk);
    n_tests++;
    if (gnt1_b !== 1'b1) begin n_fail++; $display("FAIL b_write_gnt: got %b expected 1", gnt1_b); end
    step();
    req1_b = 0;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      if (!we_b) we_lo++;
      if (done1_b && done_at < 0) done_at = t;
      step();
    end
    n_tests++;
    if (we_lo != 3) begin n_fail++; $display("FAIL b_we_pulse: got %0d expected 3", we_lo); end
    n_tests++;
    if (done_at != 6) begin n_fail++; $display("FAIL b_write_lat: got %0d expected 6", done_at); end
    n_tests++;
    if (mem_b[8'h10] !== 16'h5A00) begin n_fail++; $display("FAIL b_write_mem: got %h expected 5a00", mem_b[8'h10]); end
    done_at = -1;
    req0_b = 1; we0_b = 0; addr0_b = 21'h00021;
    @(negedge clk);
    n_tests++;
    if (gnt0_b !== 1'b1) begin n_fail++; $display("FAIL b_read_gnt: got %b expected 1", gnt0_b); end
    step();
    req0_b = 0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (done0_b && done_at < 0) begin done_at = t; rd = rdata_b; end
      step();
    end
    n_tests++;
    if (done_at != 2 || rd !== 8'h5A) begin
      n_fail++; $display("FAIL b_read: got lat %0d data %h expected lat 2 data 5a", done_at, rd);
    end
  endtask

  // Random traffic scored against a transaction-level model: priority rule
  // with a wait count, fixed latency per access kind, byte-addressed memory.
  task automatic test_random();
    logic [7:0] ref_mem [0:8191];
    int  m_starve = 0, free_at = 0, exp_done = -1, exp_owner = 0;
    bit  exp_is_rd = 0, e0, e1, g0, g1, d0, d1;
    bit  busy0 = 0, busy1 = 0;
    logic [7:0] exp_rd = 8'h00;
    int  a;
    apply_reset();
    for (int i = 0; i < 4096; i++) mem_a[i] = 16'h0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      e0 = 0; e1 = 0;
      if (cyc >= free_at && (req0_a || req1_a)) begin
        if (req1_a && (!req0_a || m_starve == MW)) e1 = 1; else e0 = 1;
      end
      n_tests++;
      if ({gnt0_a, gnt1_a} !== {e0, e1}) begin
        n_fail++; $display("FAIL rnd_gnt@%0d: got %b%b expected %b%b", cyc, gnt0_a, gnt1_a, e0, e1);
      end
      if (e0 || e1) begin
        bit w = e1 ? we1_a : we0_a;
        a = int'(e1 ? addr1_a[12:0] : addr0_a[12:0]);
        if (e1) m_starve = 0;
        else if (req1_a && m_starve < MW) m_starve++;
        exp_done  = cyc + (w ? WR_A + 3 : RD_A + 1);
        free_at   = exp_done + 1;
        exp_owner = e1 ? 1 : 0;
        exp_is_rd = !w;
        if (w) ref_mem[a] = e1 ? wdata1_a : wdata0_a;
        else   exp_rd = ref_mem[a];
      end
      n_tests++;
      if ({done0_a, done1_a} !== {cyc == exp_done && exp_owner == 0, cyc == exp_done && exp_owner == 1}) begin
        n_fail++; $display("FAIL rnd_done@%0d: got %b%b expected owner %0d at %0d", cyc, done0_a, done1_a, exp_owner, exp_done);
      end
      if (cyc == exp_done && exp_is_rd) begin
        n_tests++;
        if (rdata_a !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h expected %h", cyc, rdata_a, exp_rd); end
      end
      n_tests++;
      if (!oe_a && dqoe_a) begin n_fail++; $display("FAIL rnd_bus@%0d: got dq_oe 1 with oe_n 0 expected no overlap", cyc); end
      g0 = gnt0_a; g1 = gnt1_a; d0 = done0_a; d1 = done1_a;
      step();
      if (g0) req0_a = 0;
      if (g1) req1_a = 0;
      if (d0) busy0 = 0;
      if (d1) busy1 = 0;
      if (!busy0 && $urandom_range(0, 2) == 0) begin
        busy0 = 1; req0_a = 1; we0_a = 1'($urandom);
        addr0_a = 21'($urandom_range(0, 8191)); wdata0_a = 8'($urandom);
      end
      if (!busy1 && $urandom_range(0, 2) == 0) begin
        busy1 = 1; req1_a = 1; we1_a = 1'($urandom);
        addr1_a = 21'($urandom_range(0, 8191)); wdata1_a = 8'($urandom);
      end
    end
    req0_a = 0; req1_a = 0;
    repeat (8) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_read_p1();
    test_write_p0();
    test_timing_b();
    test_back_to_back();
    test_simul_rise();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chr_sram_arbiter.md
Name: chr_sram_arbiter

Overview:
- Shares the board's 16-bit asynchronous SRAM (CHR RAM, 1M x 16) between two byte-wide requesters.
- Port 0 is the PPU pattern fetch, which has high priority. Port 1 is the CPU/loader path, which is lower priority and protected against starvation.
- Performs one byte access at a time and sequences CE_N/OE_N/WE_N/LB_N/UB_N with programmable read and write-pulse lengths.
- Sits in nes_player between nes_console and the SRAM pins. The DQ tristate is resolved at top level.

Parameters:
- RD_CYCLES, 2, cycles OE_N is held low before DQ is sampled (1..15).
- WR_CYCLES, 2, cycles WE_N is held low (1..15).
- MAX_WAIT, 4, consecutive port-0 grants allowed while port 1 waits (1..255).

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  synchronous active-low reset
- i_req0, i_req1  in  1 each  access request; held until granted
- i_we0, i_we1  in  1 each  1 = write, 0 = read
- i_addr0, i_addr1  in  21 each  byte address; bit0 selects the byte lane
- i_wdata0, i_wdata1  in  8 each  write data
- o_gnt0, o_gnt1  out  1 each  request accepted (combinational, one cycle)
- o_done0, o_done1  out  1 each  one-cycle pulse when the access completes
- o_rdata  out  8  read byte; valid only while o_doneN is high after a read
- o_sram_addr  out  20  word address
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes
- o_sram_dq  out  16  write data, byte duplicated on both lanes
- o_sram_dq_oe  out  1  1 = drive DQ
- i_sram_dq  in  16  DQ input

Behaviour:
- Reset: synchronous, active-low.
  - All strobes = 1, dq_oe = 0, sram_addr = 0, rdata = 0.
  - gnt and done = 0.
  - FSM goes to IDLE and the starvation counter is cleared.
  - Reset mid-access abandons the access; no done is issued. The next access may start the cycle after i_rstn rises.
- States:
  - IDLE -> RD (read) or WSETUP (write)
  - RD -> DONE
  - WSETUP -> WPULSE -> WHOLD -> DONE
  - DONE -> IDLE
- Arbitration happens only in IDLE.
  - o_gntN = IDLE & winner == N & i_reqN.
  - On grant, the winner's we/addr/wdata are latched; the requester may change its inputs from the next cycle.
  - A request still high in IDLE after its done is treated as a new request.
- Priority:
  - Port 0 wins unless starve_cnt == MAX_WAIT, in which case port 1 wins.
  - starve_cnt increments when port 0 is granted while i_req1 = 1, saturating at MAX_WAIT.
  - starve_cnt clears when port 1 is granted.
  - When only one port requests, it wins.
- Lanes: addr[20:1] drives sram_addr. addr[0] = 0 selects LB_N low; addr[0] = 1 selects UB_N low. The other lane strobe stays 1.
- RD:
  - ce_n = 0 and oe_n = 0 for RD_CYCLES cycles.
  - On the last RD cycle's edge, the selected DQ byte is registered into o_rdata.
- Writes:
  - WSETUP (1 cycle): ce_n = 0, dq_oe = 1, we_n = 1.
  - WPULSE: we_n = 0 for WR_CYCLES cycles.
  - WHOLD (1 cycle): we_n = 1, dq and dq_oe still driven.
  - oe_n stays 1 throughout.
- DONE: all strobes return to 1, dq_oe = 0, o_doneN = 1 for the owning port.
- Latency with defaults:
  - Read: grant at cycle T, done at T+3; 4 cycles per access.
  - Write: done at T+5.
- Bus idle: ce_n = 1 in IDLE and DONE. DQ is never driven while oe_n = 0.
- o_rdata holds its value until the next read completes.

Decomposition:
- Package nes_sram_pkg:
  - typedef enum arb_state_t {IDLE, RD, WSETUP, WPULSE, WHOLD, DONE}
  - constant SRAM_AW = 20
  - constant BYTE_AW = 21
  - port index constants PORT_PPU = 0, PORT_CPU = 1
- Sub-module sram_arb_prio: fixed priority plus starvation counter. Inputs are req0/req1/idle; outputs are gnt0/gnt1.
- Strobe FSM and timing counter remain in chr_sram_arbiter.

Test Plan:
- Reset, then port 1 reads byte 0x00003 while memory word 0x00001 = 0xA55A:
  - gnt1 at T; ub_n = 0, lb_n = 1, oe_n = 0 during T+1..T+2.
  - done1 at T+3 with rdata = 0xA5.
- Port 0 writes 0x3C to 0x00010:
  - sram_addr = 0x00008, lb_n = 0, dq = 0x3C3C.
  - we_n low exactly 2 cycles, dq_oe = 1 for 4 cycles.
  - done0 at T+5; a readback returns 0x3C.
- req0 and req1 both held continuously with MAX_WAIT = 4:
  - grant order 0,0,0,0,1,0,0,0,0,1.
  - no two done pulses in the same cycle.
- req0 and req1 rise in the same cycle after 2 prior port-0 grants with port 1 idle:
  - port 0 wins; starve_cnt = 1 afterwards.
- i_rstn low for 1 cycle during WPULSE:
  - next cycle all strobes = 1, dq_oe = 0, no done0.
  - a new read is granted the cycle after i_rstn = 1.
- RD_CYCLES = 1, WR_CYCLES = 3:
  - read done at T+2.
  - write has we_n low exactly 3 cycles, done at T+6.
